preset_register_bank: RTL
=========================

Name: preset_register_bank

Overview:
Parametrised bank of DEPTH registers, DATAWIDTH bits each. Each register resets to a per-entry preset (INITREG + i*INITSTEP). Provides one synchronous write port and one registered read port. A restore sequencer reloads all presets on command, one entry per cycle. Holds constants and thresholds for the sorting datapath, replacing single fixed constant registers.

Parameters:
DATAWIDTH, 8, width of each register and of the data ports
DEPTH, 4, number of registers (1..256)
ADDRWIDTH, 2, address width; must satisfy 2**ADDRWIDTH >= DEPTH
INITREG, 5, preset of entry 0
INITSTEP, 0, preset increment per entry; preset(i) = (INITREG + i*INITSTEP) mod 2**DATAWIDTH

Ports:
clk  input  1  clock, all state on rising edge
lowRst  input  1  reset, asynchronous, active-low
wrEn  input  1  write strobe, sampled on clk
wrAddr  input  ADDRWIDTH  write address
wrData  input  DATAWIDTH  write data
rdAddr  input  ADDRWIDTH  read address
rdData  output  DATAWIDTH  registered read data
restoreReq  input  1  start restore sequence (level sampled, acted on in IDLE only)
busy  output  1  high while restore in progress
done  output  1  one-cycle pulse after the last preset is written
wrErr  output  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (lowRst=0, async): reg[i]=preset(i) for all i; rdData=0; busy=0; done=0; wrErr=0; FSM=IDLE; pointer=0.
- Read: rdData <= reg[rdAddr] every cycle; latency 1 clk. rdAddr>=DEPTH -> rdData <= 0.
- Read/write same address, same cycle: rdData shows the old value; the new value appears on the following read.
- Write in IDLE: wrEn=1 and wrAddr<DEPTH -> reg[wrAddr] <= wrData at that edge. wrAddr>=DEPTH -> no write; wrErr=1 next cycle.
- FSM IDLE: restoreReq=1 -> RESTORE, pointer=0, busy=1 from next cycle. A write presented in the same cycle as restoreReq is performed, then overwritten by the restore.
- FSM RESTORE: each cycle reg[pointer] <= preset(pointer), pointer++. On the cycle writing entry DEPTH-1 -> IDLE; busy=0 and done=1 on the next cycle (done lasts exactly 1 cycle).
- Restore takes DEPTH cycles with busy=1. DEPTH=1 -> busy for one cycle.
- During RESTORE: wrEn ignored and wrErr pulses one cycle later for each rejected strobe. restoreReq ignored. Reads still serviced and return current contents, which may be partially restored.
- restoreReq held high: a new restore starts on the first IDLE cycle after done.
- Reset mid-restore: immediate return to reset state; all entries at preset.
- Preset arithmetic: computed at elaboration, truncated to DATAWIDTH; no runtime multiplier.

Optional Feature:
Macro WRITE_LOCK_EN.
- Defined: extra input port writeLock (1 bit). While writeLock=1, all wrEn writes are rejected and wrErr pulses next cycle. Restore and reads are unaffected.
- Undefined: port absent; writes are rejected only during RESTORE or for an out-of-range address.

Test Plan:
- Reset, DATAWIDTH=8, DEPTH=4, INITREG=5, INITSTEP=3; read addr 0..3 -> rdData 5, 8, 11, 14, each 1 clk after rdAddr applied; busy=done=wrErr=0.
- Write 0xAA to addr 2, read addr 2 in the same cycle -> rdData=11; read again next cycle -> rdData=0xAA.
- After writing 0xFF to all entries, pulse restoreReq -> busy=1 for exactly 4 cycles, then done pulses once; reads return 5, 8, 11, 14.
- wrEn with wrAddr=1 during the 2nd restore cycle -> wrErr pulses one cycle later; reg[1] ends at 8.
- Assert lowRst=0 during restore cycle 2 -> busy=0 immediately; all entries at preset; no done pulse.
- INITREG=250, INITSTEP=3 -> presets 250, 253, 0, 3 (wrap mod 256). With WRITE_LOCK_EN and writeLock=1: write attempt -> wrErr pulses; data unchanged.

Source files
------------

// File: rtl/preset_register_bank.sv
// Register bank with per-entry elaboration-time presets, one write port, one registered read port
// and a one-entry-per-cycle restore sequencer. Optional macro WRITE_LOCK_EN adds the writeLock input.
module preset_register_bank #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDRWIDTH = 2,
  parameter int unsigned INITREG   = 5,
  parameter int unsigned INITSTEP  = 0
) (
  input  logic                 clk,
  input  logic                 lowRst,
  input  logic                 wrEn,
  input  logic [ADDRWIDTH-1:0] wrAddr,
  input  logic [DATAWIDTH-1:0] wrData,
  input  logic [ADDRWIDTH-1:0] rdAddr,
  output logic [DATAWIDTH-1:0] rdData,
  input  logic                 restoreReq,
`ifdef WRITE_LOCK_EN
  input  logic                 writeLock,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 wrErr
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RESTORE = 1'b1
  } state_t;

  state_t                 r_state;
  logic [ADDRWIDTH-1:0]   r_ptr;
  logic                   w_restoring;
  logic                   w_lock;
  logic                   w_wr_in_range;
  logic                   w_wr_ok;
  logic [DATAWIDTH-1:0]   w_rd_sel;
  logic [DATAWIDTH-1:0]   w_regs [DEPTH];

  // Preset value of entry idx, wrapped to the register width; evaluated only as a constant.
  function automatic logic [DATAWIDTH-1:0] preset_f(input int unsigned idx);
    logic [63:0] v;
    v = 64'(INITREG) + 64'(idx) * 64'(INITSTEP);
    return DATAWIDTH'(v);
  endfunction

`ifdef WRITE_LOCK_EN
  assign w_lock = writeLock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_restoring   = (r_state == S_RESTORE);
  assign w_wr_in_range = (32'(wrAddr) < DEPTH);
  assign w_wr_ok       = wrEn && !w_restoring && w_wr_in_range && !w_lock;

  // One register per entry so each carries its own constant reset/restore value.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    localparam logic [DATAWIDTH-1:0] PRESET = preset_f(g);
    logic [DATAWIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge lowRst) begin
      if (!lowRst) begin
        r_q <= PRESET;
      end else if (w_restoring && (r_ptr == ADDRWIDTH'(g))) begin
        r_q <= PRESET;
      end else if (w_wr_ok && (wrAddr == ADDRWIDTH'(g))) begin
        r_q <= wrData;
      end
    end

    assign w_regs[g] = r_q;
  end

  // Unmapped read addresses fall through to zero.
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdAddr == ADDRWIDTH'(i)) begin
        w_rd_sel = w_regs[i];
      end
    end
  end

  always_ff @(posedge clk or negedge lowRst) begin
    if (!lowRst) begin
      rdData <= '0;
      wrErr  <= 1'b0;
    end else begin
      rdData <= w_rd_sel;
      wrErr  <= wrEn && !w_wr_ok;
    end
  end

  // Restore sequencer: walks the pointer over every entry, then pulses done.
  always_ff @(posedge clk or negedge lowRst) begin
    if (!lowRst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (restoreReq) begin
            r_state <= S_RESTORE;
            r_ptr   <= '0;
            busy    <= 1'b1;
          end
        end
        S_RESTORE: begin
          if (r_ptr == ADDRWIDTH'(DEPTH - 1)) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_ptr <= r_ptr + ADDRWIDTH'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ptr   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
